sz_code_packer: RTL and testbench

//  Downstream neighbour of the SZ compressor core. Packs the 2-bit per-sample prediction/type codes
//  (data_out stream) into 32-bit words and buffers them in a small FWFT FIFO for the DRAM writer / Gzip.

---
 rtl/sz_code_packer_if.sv | 34 +++
 rtl/sz_code_packer.sv | 124 ++++++++++++
 tb/tb_sz_code_packer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sz_code_packer_if.sv
// Handshake bundle between the code packer, the SZ compressor core that feeds it,
// and the word consumer (DRAM writer / Gzip).
interface sz_code_packer_if #(
  parameter int CODE_W = 2,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 3
);
  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              code_ready;
  logic              flush;
  logic [WORD_W-1:0] word_out;
  logic [4:0]        word_codes;
  logic              word_last;
  logic              word_valid;
  logic              word_ready;
  logic [ADDR_W:0]   fifo_count;
  logic              flush_done;
  logic [31:0]       word_total;

  // Producer/consumer side of the packer
  modport master (
    output code_in, code_valid, flush, word_ready,
    input  code_ready, word_out, word_codes, word_last, word_valid,
           fifo_count, flush_done, word_total
  );

  // Packer side
  modport slave (
    input  code_in, code_valid, flush, word_ready,
    output code_ready, word_out, word_codes, word_last, word_valid,
           fifo_count, flush_done, word_total
  );
endinterface

// File: rtl/sz_code_packer.sv
// Packs 2-bit SZ prediction/type codes LSB-first into 32-bit words and queues them
// in a small first-word-fall-through FIFO. End-of-stream flush zero-pads the partial
// word, tags it last, and pulses flush_done once the FIFO has fully drained.
module sz_code_packer #(
  parameter int CODE_W     = 2,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input logic             clk,
  input logic             rst,
  sz_code_packer_if.slave bus
);
  localparam int CPW    = WORD_W / CODE_W;
  localparam int FILL_W = $clog2(CPW);
  localparam int ENT_W  = WORD_W + 6;   // {last, codes[4:0], word}

  typedef enum logic [1:0] {PACK, FLUSH_WR, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [FILL_W-1:0]   fill, fill_nxt;
  logic [WORD_W-1:0]   accum, accum_nxt, merged;
  logic [ENT_W-1:0]    mem [FIFO_DEPTH];
  logic [ENT_W-1:0]    push_ent, head_ent;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count;
  logic [31:0]         total;
  logic                push, pop, full, empty, accept, done;

  assign full   = (count == (ADDR_W+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign accept = bus.code_valid && bus.code_ready;
  assign pop    = !empty && bus.word_ready;
  assign merged = accum | (WORD_W'(bus.code_in) << (int'(fill) * CODE_W));

  // Empty FIFO presents zeros so the head never shows stale or uninitialised storage
  assign head_ent = empty ? '0 : mem[rd_ptr];

  assign bus.code_ready = (state == PACK) && !full;
  assign bus.word_valid = !empty;
  assign bus.word_out   = head_ent[WORD_W-1:0];
  assign bus.word_codes = head_ent[WORD_W+4:WORD_W];
  assign bus.word_last  = head_ent[WORD_W+5];
  assign bus.fifo_count = count;
  assign bus.flush_done = done;
  assign bus.word_total = total;

  // Next-state, accumulator update and FIFO push decisions
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    accum_nxt = accum;
    push      = 1'b0;
    push_ent  = '0;
    done      = 1'b0;
    case (state)
      PACK: begin
        if (accept) begin
          if (fill == FILL_W'(CPW - 1)) begin
            // A completing code that arrives with flush closes the stream itself
            push      = 1'b1;
            push_ent  = {bus.flush, 5'(CPW), merged};
            fill_nxt  = '0;
            accum_nxt = '0;
          end else begin
            fill_nxt  = fill + 1'b1;
            accum_nxt = merged;
          end
        end
        if (bus.flush) state_nxt = FLUSH_WR;
      end
      FLUSH_WR: begin
        if (fill == '0) begin
          state_nxt = DRAIN;
        end else if (!full) begin
          push      = 1'b1;
          push_ent  = {1'b1, 5'(fill), accum};
          fill_nxt  = '0;
          accum_nxt = '0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (empty) begin
          done      = 1'b1;
          state_nxt = PACK;
        end
      end
      default: state_nxt = PACK;
    endcase
  end

  // Control state, packing accumulator, FIFO pointers/occupancy and pop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PACK;
      fill   <= '0;
      accum  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      total  <= '0;
    end else begin
      state <= state_nxt;
      fill  <= fill_nxt;
      accum <= accum_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        total  <= total + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; push is only ever asserted when a slot is free
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end
endmodule

// File: tb/tb_sz_code_packer.sv
// Directed bench for sz_code_packer: word packing, flush variants, full-FIFO
// backpressure and mid-stream reset, with hand-computed expected values.
module tb_sz_code_packer;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  sz_code_packer_if #(.CODE_W(2), .WORD_W(32), .ADDR_W(3)) bus ();

  sz_code_packer #(
    .CODE_W(2), .WORD_W(32), .FIFO_DEPTH(8), .ADDR_W(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(bus.word_valid), 64'd0);
    chk({tag, "_out"},   64'(bus.word_out),   64'd0);
    chk({tag, "_codes"}, 64'(bus.word_codes), 64'd0);
    chk({tag, "_last"},  64'(bus.word_last),  64'd0);
    chk({tag, "_done"},  64'(bus.flush_done), 64'd0);
    chk({tag, "_total"}, 64'(bus.word_total), 64'd0);
    chk({tag, "_count"}, 64'(bus.fifo_count), 64'd0);
    chk({tag, "_ready"}, 64'(bus.code_ready), 64'd1);
  endtask

  initial begin
    logic [1:0] c;
    n_cmp = 0;
    n_bad = 0;
    rst            = 1'b1;
    bus.code_in    = '0;
    bus.code_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_reset_state("rst");

    // Test 1: 0,1,2,3 repeating -> 0xE4E4E4E4
    bus.word_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      c = 2'(k % 4);
      bus.code_in    = c;
      bus.code_valid = 1'b1;
      if (k == 15) chk("t1_no_early_valid", 64'(bus.word_valid), 64'd0);
      tick();
    end
    bus.code_valid = 1'b0;
    chk("t1_valid", 64'(bus.word_valid), 64'd1);
    chk("t1_word",  64'(bus.word_out),   64'hE4E4E4E4);
    chk("t1_codes", 64'(bus.word_codes), 64'd16);
    chk("t1_last",  64'(bus.word_last),  64'd0);
    tick();
    chk("t1_popped", 64'(bus.word_valid), 64'd0);
    chk("t1_total",  64'(bus.word_total), 64'd1);

    // Test 2: five 2'b11 codes then flush -> 0x3FF, codes=5, last=1
    bus.word_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.code_in    = 2'b11;
      bus.code_valid = 1'b1;
      tick();
    end
    bus.code_valid = 1'b0;
    bus.flush      = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t2_flushwr_ready", 64'(bus.code_ready), 64'd0);
    tick();
    chk("t2_valid", 64'(bus.word_valid), 64'd1);
    chk("t2_word",  64'(bus.word_out),   64'h000003FF);
    chk("t2_codes", 64'(bus.word_codes), 64'd5);
    chk("t2_last",  64'(bus.word_last),  64'd1);
    chk("t2_done_early", 64'(bus.flush_done), 64'd0);
    bus.word_ready = 1'b1;
    tick();
    chk("t2_done",  64'(bus.flush_done), 64'd1);
    chk("t2_total", 64'(bus.word_total), 64'd2);
    tick();
    chk("t2_done_once", 64'(bus.flush_done), 64'd0);
    chk("t2_back_pack", 64'(bus.code_ready), 64'd1);

    // Test 3: 128 codes with word_ready low; word w carries value w
    bus.word_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 16; k++) begin
        if (k == 0)      c = 2'(w % 4);
        else if (k == 1) c = 2'(w / 4);
        else             c = 2'b00;
        bus.code_in    = c;
        bus.code_valid = 1'b1;
        chk("t3_ready", 64'(bus.code_ready), 64'd1);
        tick();
      end
    end
    bus.code_in = 2'b11;
    chk("t3_count_full", 64'(bus.fifo_count), 64'd8);
    chk("t3_stall",      64'(bus.code_ready), 64'd0);
    tick();
    chk("t3_still_full", 64'(bus.fifo_count), 64'd8);
    bus.code_valid = 1'b0;
    bus.word_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      chk("t3_valid", 64'(bus.word_valid), 64'd1);
      chk("t3_word",  64'(bus.word_out),   64'(w));
      chk("t3_codes", 64'(bus.word_codes), 64'd16);
      tick();
    end
    chk("t3_empty", 64'(bus.word_valid), 64'd0);
    chk("t3_total", 64'(bus.word_total), 64'd8);

    // Test 4: flush with nothing pending; flush at N, done at N+2, PACK at N+3
    bus.flush = 1'b1;
    #1;
    chk("t4_n_done", 64'(bus.flush_done), 64'd0);
    tick();
    bus.flush = 1'b0;
    chk("t4_n1_done",  64'(bus.flush_done), 64'd0);
    chk("t4_n1_ready", 64'(bus.code_ready), 64'd0);
    tick();
    chk("t4_n2_done",  64'(bus.flush_done), 64'd1);
    chk("t4_n2_valid", 64'(bus.word_valid), 64'd0);
    tick();
    chk("t4_n3_done",  64'(bus.flush_done), 64'd0);
    chk("t4_n3_ready", 64'(bus.code_ready), 64'd1);
    chk("t4_n3_valid", 64'(bus.word_valid), 64'd0);

    // Test 5: 16th code with flush -> single word, last=1, no padded extra
    bus.word_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.code_in    = (k == 15) ? 2'b10 : 2'b01;
      bus.code_valid = 1'b1;
      bus.flush      = (k == 15);
      tick();
    end
    bus.code_valid = 1'b0;
    bus.flush      = 1'b0;
    chk("t5_word",  64'(bus.word_out),   64'h95555555);
    chk("t5_codes", 64'(bus.word_codes), 64'd16);
    chk("t5_last",  64'(bus.word_last),  64'd1);
    tick();
    tick();
    chk("t5_count", 64'(bus.fifo_count), 64'd1);
    chk("t5_done_wait", 64'(bus.flush_done), 64'd0);
    bus.word_ready = 1'b1;
    tick();
    chk("t5_done",  64'(bus.flush_done), 64'd1);
    chk("t5_empty", 64'(bus.fifo_count), 64'd0);
    chk("t5_total", 64'(bus.word_total), 64'd9);
    tick();
    chk("t5_no_extra", 64'(bus.word_valid), 64'd0);

    // Test 6: reset mid-word discards partial bits
    bus.word_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.code_in    = 2'b11;
      bus.code_valid = 1'b1;
      tick();
    end
    bus.code_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_reset_state("t6_rst");
    for (int k = 0; k < 16; k++) begin
      c = 2'(k % 4);
      bus.code_in    = c;
      bus.code_valid = 1'b1;
      tick();
    end
    bus.code_valid = 1'b0;
    chk("t6_word",  64'(bus.word_out),   64'hE4E4E4E4);
    chk("t6_codes", 64'(bus.word_codes), 64'd16);
    chk("t6_count", 64'(bus.fifo_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
